// File: rtl/ahb_master_if_pkg.sv
// Shared AHB encodings (HTRANS, HRESP, HBURST) and FSM state constants for the
// single-transfer AHB master front end.
package ahb_master_if_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ADDR = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    // RETRY and SPLIT both mean "same command must be re-arbitrated and re-issued"
    function automatic logic resp_is_reissue(input logic [1:0] resp);
        return (resp == HRESP_RETRY) || (resp == HRESP_SPLIT);
    endfunction

endpackage

// File: rtl/ahb_master_if_if.sv
// AHB master-side bus bundle: arbiter handshake plus address/data phase signals.
interface ahb_master_if_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              HBUSREQ_o;
    logic              HLOCK_o;
    logic              HGRANT_i;
    logic              HREADY_i;
    logic [1:0]        HRESP_i;
    logic [DATA_W-1:0] HRDATA_i;
    logic [ADDR_W-1:0] HADDR_o;
    logic [1:0]        HTRANS_o;
    logic              HWRITE_o;
    logic [2:0]        HSIZE_o;
    logic [2:0]        HBURST_o;
    logic [DATA_W-1:0] HWDATA_o;

    modport master (
        output HBUSREQ_o, HLOCK_o, HADDR_o, HTRANS_o, HWRITE_o, HSIZE_o, HBURST_o, HWDATA_o,
        input  HGRANT_i, HREADY_i, HRESP_i, HRDATA_i
    );

    modport slave (
        input  HBUSREQ_o, HLOCK_o, HADDR_o, HTRANS_o, HWRITE_o, HSIZE_o, HBURST_o, HWDATA_o,
        output HGRANT_i, HREADY_i, HRESP_i, HRDATA_i
    );
endinterface

// File: rtl/ahb_master_if.sv
// Single-transfer AHB master: core command -> bus request, address and data phases, ack.
// Build option AHB_MST_RETRY_LIMIT_EN bounds RETRY/SPLIT re-issues at MAX_RETRY.
module ahb_master_if
    import ahb_master_if_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
`ifdef AHB_MST_RETRY_LIMIT_EN
    ,
    parameter int unsigned MAX_RETRY = 15
`endif
) (
    input  logic              HCLK,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [2:0]        size_i,
    input  logic              lock_i,
    output logic              busy_o,
    output logic              ack_o,
    output logic              err_o,
    output logic [DATA_W-1:0] rdata_o,
    ahb_master_if_if.master   bus
);

    logic [1:0]        state_q, state_nxt;

    logic              cmd_we_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic [2:0]        cmd_size_q;
    logic              cmd_lock_q;

    logic              busy_q, busy_nxt;
    logic              ack_q, ack_nxt;
    logic              err_q, err_nxt;
    logic [DATA_W-1:0] rdata_q, rdata_nxt;
    logic              busreq_q, busreq_nxt;
    logic              hlock_q, hlock_nxt;
    logic [ADDR_W-1:0] haddr_q, haddr_nxt;
    logic [1:0]        htrans_q, htrans_nxt;
    logic              hwrite_q, hwrite_nxt;
    logic [2:0]        hsize_q, hsize_nxt;
    logic [DATA_W-1:0] hwdata_q, hwdata_nxt;

    logic              accept_c;
    logic              retry_ok_c;

    assign accept_c = (state_q == ST_IDLE) && req_i;

`ifdef AHB_MST_RETRY_LIMIT_EN
    localparam int unsigned RETRY_CNT_W = 4;
    logic [RETRY_CNT_W-1:0] retry_cnt_q;

    // Re-issue allowed only while one more attempt keeps the count within MAX_RETRY
    assign retry_ok_c = (retry_cnt_q != RETRY_CNT_W'(MAX_RETRY));

    always_ff @(posedge HCLK or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            retry_cnt_q <= '0;
        end else if ((state_q == ST_DATA) && bus.HREADY_i &&
                     resp_is_reissue(bus.HRESP_i) && retry_ok_c) begin
            retry_cnt_q <= retry_cnt_q + RETRY_CNT_W'(1);
        end
    end
`else
    assign retry_ok_c = 1'b1;
`endif

    // Command latch: captured only when a request is accepted in IDLE
    always_ff @(posedge HCLK or negedge rst_n) begin
        if (!rst_n) begin
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_size_q  <= '0;
            cmd_lock_q  <= 1'b0;
        end else if (accept_c) begin
            cmd_we_q    <= we_i;
            cmd_addr_q  <= addr_i;
            cmd_wdata_q <= wdata_i;
            cmd_size_q  <= size_i;
            cmd_lock_q  <= lock_i;
        end
    end

    always_ff @(posedge HCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            busreq_q <= 1'b0;
            hlock_q  <= 1'b0;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hwdata_q <= '0;
        end else begin
            state_q  <= state_nxt;
            busy_q   <= busy_nxt;
            ack_q    <= ack_nxt;
            err_q    <= err_nxt;
            rdata_q  <= rdata_nxt;
            busreq_q <= busreq_nxt;
            hlock_q  <= hlock_nxt;
            haddr_q  <= haddr_nxt;
            htrans_q <= htrans_nxt;
            hwrite_q <= hwrite_nxt;
            hsize_q  <= hsize_nxt;
            hwdata_q <= hwdata_nxt;
        end
    end

    // Next-state and next-output logic; all outputs hold unless a transition updates them
    always_comb begin
        state_nxt  = state_q;
        ack_nxt    = 1'b0;
        err_nxt    = 1'b0;
        rdata_nxt  = rdata_q;
        busreq_nxt = busreq_q;
        hlock_nxt  = hlock_q;
        haddr_nxt  = haddr_q;
        htrans_nxt = htrans_q;
        hwrite_nxt = hwrite_q;
        hsize_nxt  = hsize_q;
        hwdata_nxt = hwdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    busreq_nxt = 1'b1;
                    hlock_nxt  = lock_i;
                    state_nxt  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.HGRANT_i && bus.HREADY_i) begin
                    htrans_nxt = HTRANS_NONSEQ;
                    haddr_nxt  = cmd_addr_q;
                    hwrite_nxt = cmd_we_q;
                    hsize_nxt  = cmd_size_q;
                    state_nxt  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus.HREADY_i) begin
                    htrans_nxt = HTRANS_IDLE;
                    hwdata_nxt = cmd_wdata_q;
                    busreq_nxt = cmd_lock_q;
                    state_nxt  = ST_DATA;
                end
            end
            ST_DATA: begin
                // HREADY low covers both OKAY wait states and the first cycle of a two-cycle response
                if (bus.HREADY_i) begin
                    if (bus.HRESP_i == HRESP_OKAY) begin
                        ack_nxt    = 1'b1;
                        if (!cmd_we_q) rdata_nxt = bus.HRDATA_i;
                        busreq_nxt = 1'b0;
                        hlock_nxt  = 1'b0;
                        state_nxt  = ST_IDLE;
                    end else if (resp_is_reissue(bus.HRESP_i) && retry_ok_c) begin
                        busreq_nxt = 1'b1;
                        state_nxt  = ST_REQ;
                    end else begin
                        ack_nxt    = 1'b1;
                        err_nxt    = 1'b1;
                        busreq_nxt = 1'b0;
                        hlock_nxt  = 1'b0;
                        state_nxt  = ST_IDLE;
                    end
                end
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    assign busy_o        = busy_q;
    assign ack_o         = ack_q;
    assign err_o         = err_q;
    assign rdata_o       = rdata_q;
    assign bus.HBUSREQ_o = busreq_q;
    assign bus.HLOCK_o   = hlock_q;
    assign bus.HADDR_o   = haddr_q;
    assign bus.HTRANS_o  = htrans_q;
    assign bus.HWRITE_o  = hwrite_q;
    assign bus.HSIZE_o   = hsize_q;
    assign bus.HBURST_o  = HBURST_SINGLE;
    assign bus.HWDATA_o  = hwdata_q;

endmodule

// File: tb/tb_ahb_master_if.sv
// Bench for ahb_master_if: a scheduled arbiter/slave drives each transfer while the
// expected bus phases, ack timing, err and rdata are derived from that schedule.
module tb_ahb_master_if;
    import ahb_master_if_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TB_MAX_RETRY = 2;
    localparam int OUTS_W = 110;
    localparam int K_REQ  = 0;
    localparam int K_ADDR = 1;
    localparam int K_DATA = 2;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic              rst_n;
    logic              req_i, we_i, lock_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic [2:0]        size_i;
    logic              busy_o, ack_o, err_o;
    logic [DATA_W-1:0] rdata_o;

    ahb_master_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef AHB_MST_RETRY_LIMIT_EN
    ahb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RETRY(TB_MAX_RETRY)) dut (
`else
    ahb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
`endif
        .HCLK(HCLK), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .size_i(size_i), .lock_i(lock_i), .busy_o(busy_o),
        .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o), .bus(bus)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_rdata = '0;

    // Per-attempt schedule: grant delay, data wait states, final response of the attempt
    int          n_att;
    int          att_g [8];
    int          att_w [8];
    logic [1:0]  att_r [8];
    logic        mix_gnt;

    function automatic logic [OUTS_W-1:0] all_outs();
        return {busy_o, ack_o, err_o, rdata_o, bus.HBUSREQ_o, bus.HLOCK_o, bus.HADDR_o,
                bus.HTRANS_o, bus.HWRITE_o, bus.HSIZE_o, bus.HBURST_o, bus.HWDATA_o};
    endfunction

    task automatic bus_idle();
        req_i = 1'b0; we_i = 1'b0; lock_i = 1'b0; addr_i = '0; wdata_i = '0; size_i = '0;
        bus.HGRANT_i = 1'b0; bus.HREADY_i = 1'b1; bus.HRESP_i = HRESP_OKAY; bus.HRDATA_i = '0;
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] size, input logic lock, input logic [31:0] hrdata,
                           input int abort_at);
        int         kind [$];
        logic       gnt [$];
        logic       rdy [$];
        logic [1:0] rsp [$];
        logic       exp_err, g, r;
        logic [31:0] exp_rdata;
        int         n_ns;
        n_ns      = 0;
        exp_err   = (att_r[n_att-1] != HRESP_OKAY);
        exp_rdata = (!we && !exp_err) ? hrdata : model_rdata;
        for (int a = 0; a < n_att; a++) begin
            for (int i = 0; i < att_g[a]; i++) begin
                g = mix_gnt ? 1'($urandom_range(0, 1)) : 1'b0;
                r = g ? 1'b0 : 1'($urandom_range(0, 1));
                kind.push_back(K_REQ); gnt.push_back(g); rdy.push_back(r); rsp.push_back(HRESP_OKAY);
            end
            kind.push_back(K_REQ);  gnt.push_back(1'b1); rdy.push_back(1'b1); rsp.push_back(HRESP_OKAY);
            kind.push_back(K_ADDR); gnt.push_back(att_g[a] == 0); rdy.push_back(1'b1); rsp.push_back(HRESP_OKAY);
            for (int i = 0; i < att_w[a]; i++) begin
                kind.push_back(K_DATA); gnt.push_back(1'b0); rdy.push_back(1'b0); rsp.push_back(HRESP_OKAY);
            end
            if (att_r[a] != HRESP_OKAY) begin
                kind.push_back(K_DATA); gnt.push_back(1'b0); rdy.push_back(1'b0); rsp.push_back(att_r[a]);
            end
            kind.push_back(K_DATA); gnt.push_back(1'b0); rdy.push_back(1'b1); rsp.push_back(att_r[a]);
        end

        @(negedge HCLK);
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; size_i = size; lock_i = lock;
        bus.HGRANT_i = 1'b0; bus.HREADY_i = 1'b1; bus.HRESP_i = HRESP_OKAY;

        for (int s = 0; s < kind.size(); s++) begin
            @(negedge HCLK);
            if (kind[s] == K_REQ) begin
                checks++;
                if ({bus.HBUSREQ_o, bus.HLOCK_o, bus.HTRANS_o, busy_o, ack_o} !==
                    {1'b1, lock, HTRANS_IDLE, 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL req_phase slot=%0d got busreq,lock,trans,busy,ack=%b exp=%b", s,
                             {bus.HBUSREQ_o, bus.HLOCK_o, bus.HTRANS_o, busy_o, ack_o},
                             {1'b1, lock, HTRANS_IDLE, 1'b1, 1'b0});
                end
            end else if (kind[s] == K_ADDR) begin
                n_ns++;
                checks++;
                if ({bus.HTRANS_o, bus.HADDR_o, bus.HWRITE_o, bus.HSIZE_o, bus.HBURST_o} !==
                    {HTRANS_NONSEQ, addr, we, size, HBURST_SINGLE}) begin
                    failures++;
                    $display("FAIL addr_phase slot=%0d got trans=%b addr=%h wr=%b size=%0d burst=%0d exp trans=%b addr=%h wr=%b size=%0d",
                             s, bus.HTRANS_o, bus.HADDR_o, bus.HWRITE_o, bus.HSIZE_o, bus.HBURST_o,
                             HTRANS_NONSEQ, addr, we, size);
                end
            end else begin
                checks++;
                if ({bus.HTRANS_o, bus.HWDATA_o, bus.HBUSREQ_o, ack_o} !==
                    {HTRANS_IDLE, wdata, lock, 1'b0}) begin
                    failures++;
                    $display("FAIL data_phase slot=%0d got trans=%b hwdata=%h busreq=%b ack=%b exp trans=%b hwdata=%h busreq=%b ack=0",
                             s, bus.HTRANS_o, bus.HWDATA_o, bus.HBUSREQ_o, ack_o, HTRANS_IDLE, wdata, lock);
                end
            end

            if (s == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if (all_outs() !== '0) begin
                    failures++;
                    $display("FAIL async_reset got=%h exp=0", all_outs());
                end
                bus_idle();
                @(negedge HCLK);
                @(negedge HCLK);
                rst_n = 1'b1;
                model_rdata = '0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge HCLK);
                    checks++;
                    if ({ack_o, busy_o, bus.HBUSREQ_o} !== 3'b000) begin
                        failures++;
                        $display("FAIL post_reset_idle cycle=%0d got ack,busy,busreq=%b exp=000", c,
                                 {ack_o, busy_o, bus.HBUSREQ_o});
                    end
                end
                return;
            end

            // Garbage on the core port while busy must be ignored
            req_i   = 1'($urandom_range(0, 1));
            we_i    = 1'($urandom_range(0, 1));
            lock_i  = 1'($urandom_range(0, 1));
            addr_i  = $urandom;
            wdata_i = $urandom;
            size_i  = 3'($urandom_range(0, 7));
            bus.HGRANT_i = gnt[s];
            bus.HREADY_i = rdy[s];
            bus.HRESP_i  = rsp[s];
            bus.HRDATA_i = (s == kind.size() - 1) ? hrdata : $urandom;
        end

        @(negedge HCLK);
        bus_idle();
        checks++;
        if ({ack_o, err_o, busy_o, bus.HBUSREQ_o, bus.HLOCK_o, bus.HTRANS_o} !==
            {1'b1, exp_err, 1'b0, 1'b0, 1'b0, HTRANS_IDLE}) begin
            failures++;
            $display("FAIL completion got ack,err,busy,busreq,lock,trans=%b exp=%b",
                     {ack_o, err_o, busy_o, bus.HBUSREQ_o, bus.HLOCK_o, bus.HTRANS_o},
                     {1'b1, exp_err, 1'b0, 1'b0, 1'b0, HTRANS_IDLE});
        end
        checks++;
        if (rdata_o !== exp_rdata) begin
            failures++;
            $display("FAIL rdata got=%h exp=%h", rdata_o, exp_rdata);
        end
        checks++;
        if (n_ns !== n_att) begin
            failures++;
            $display("FAIL nonseq_count got=%0d exp=%0d", n_ns, n_att);
        end
        model_rdata = exp_rdata;
        @(negedge HCLK);
        checks++;
        if ({ack_o, err_o, busy_o} !== 3'b000 || rdata_o !== exp_rdata) begin
            failures++;
            $display("FAIL after_ack got ack,err,busy=%b rdata=%h exp 000 rdata=%h",
                     {ack_o, err_o, busy_o}, rdata_o, exp_rdata);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        repeat (3) @(negedge HCLK);
        checks++;
        if (all_outs() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", all_outs());
        end
        rst_n = 1'b1;
        model_rdata = '0;
        @(negedge HCLK);
        checks++;
        if ({busy_o, ack_o, bus.HBUSREQ_o, bus.HTRANS_o} !== {3'b000, HTRANS_IDLE}) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=00000", {busy_o, ack_o, bus.HBUSREQ_o, bus.HTRANS_o});
        end
    endtask

    task automatic test_parked_read();
        n_att = 1; att_g[0] = 0; att_w[0] = 0; att_r[0] = HRESP_OKAY; mix_gnt = 1'b0;
        run_txn(1'b0, 32'h0000_0010, $urandom, 3'b010, 1'b0, 32'hDEAD_BEEF, -1);
    endtask

    task automatic test_write_grant_wait();
        n_att = 1; att_g[0] = 5; att_w[0] = 2; att_r[0] = HRESP_OKAY; mix_gnt = 1'b0;
        run_txn(1'b1, 32'h0000_1000, 32'h1234_5678, 3'b010, 1'b0, $urandom, -1);
    endtask

    task automatic test_error();
        n_att = 1; att_g[0] = 0; att_w[0] = 1; att_r[0] = HRESP_ERROR; mix_gnt = 1'b0;
        run_txn(1'b0, 32'h0000_0200, $urandom, 3'b010, 1'b0, $urandom, -1);
    endtask

    task automatic test_retry();
        n_att = 3; mix_gnt = 1'b0;
        for (int a = 0; a < 3; a++) begin att_g[a] = 0; att_w[a] = 0; att_r[a] = HRESP_RETRY; end
        att_r[2] = HRESP_OKAY;
        run_txn(1'b0, 32'h0000_2000, $urandom, 3'b010, 1'b0, 32'hA5A5_0F0F, -1);
    endtask

    task automatic test_split_limit();
        mix_gnt = 1'b0;
`ifdef AHB_MST_RETRY_LIMIT_EN
        n_att = TB_MAX_RETRY + 1;
        for (int a = 0; a < n_att; a++) begin att_g[a] = 0; att_w[a] = 0; att_r[a] = HRESP_SPLIT; end
`else
        n_att = 5;
        for (int a = 0; a < n_att; a++) begin att_g[a] = 1; att_w[a] = 0; att_r[a] = HRESP_SPLIT; end
        att_r[n_att-1] = HRESP_OKAY;
`endif
        run_txn(1'b0, 32'h0000_3000, $urandom, 3'b001, 1'b1, $urandom, -1);
    endtask

    task automatic test_reset_mid();
        n_att = 1; att_g[0] = 1; att_w[0] = 3; att_r[0] = HRESP_OKAY; mix_gnt = 1'b0;
        run_txn(1'b0, 32'h0000_4000, $urandom, 3'b010, 1'b0, $urandom, 4);
        n_att = 1; att_g[0] = 0; att_w[0] = 0; att_r[0] = HRESP_OKAY;
        run_txn(1'b0, 32'h0000_4004, $urandom, 3'b010, 1'b0, 32'h600D_CAFE, -1);
    endtask

    task automatic test_random(input int n);
        for (int t = 0; t < n; t++) begin
            n_att   = $urandom_range(1, 3);
            mix_gnt = 1'b1;
            for (int a = 0; a < n_att; a++) begin
                att_g[a] = $urandom_range(0, 3);
                att_w[a] = $urandom_range(0, 3);
                att_r[a] = ($urandom_range(0, 1) == 0) ? HRESP_RETRY : HRESP_SPLIT;
            end
            att_r[n_att-1] = ($urandom_range(0, 3) == 0) ? HRESP_ERROR : HRESP_OKAY;
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), $urandom, -1);
        end
    endtask

    initial begin
        test_reset();
        test_parked_read();
        test_write_grant_wait();
        test_error();
        test_retry();
        test_split_limit();
        test_reset_mid();
        test_random(25);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
